// File: rtl/gnrl_ram_1r1w.sv
// gnrl_ram_1r1w - simple-dual-port RAM, one write port and one read port
//   usable in the same cycle. Used as ITCM/DTCM backing store and as a
//   general buffer RAM.
//
// Ports
//   i_clk      clock, all state on rising edge
//   i_rst_n    async active-low reset (read pipeline only, array untouched)
//   i_wr_en    write request
//   i_wr_addr  write address (byte or word, see BYTE_ADDR)
//   i_wr_data  write data
//   i_wr_mask  per-lane write enable, lane i = bits [8i+7:8i], last lane
//              takes all remaining upper bits
//   i_rd_en    read request, one per cycle, no handshake
//   i_rd_addr  read address
//   o_rd_data  read data, valid while o_rd_vld=1, held otherwise
//   o_rd_vld   one-cycle pulse per completed read
//
// Read latency is 1 (OUT_REG=0) or 2 (OUT_REG=1) cycles after the request
// cycle. Out-of-range indices drop writes and read back as 0 (still valid).

// Per-lane storage: each lane owns its own array so lane writes never share
// a driver.
module gnrl_ram_1r1w_lane #(
  parameter int LW = 8,
  parameter int DP = 512,
  parameter int IW = 9
) (
  input  logic          i_clk,
  input  logic          i_we,
  input  logic [IW-1:0] i_widx,
  input  logic [LW-1:0] i_wdata,
  input  logic [IW-1:0] i_ridx,
  output logic [LW-1:0] o_rdata
);
  logic [LW-1:0] r_mem [DP];

  always_ff @(posedge i_clk) begin
    if (i_we) r_mem[i_widx] <= i_wdata;
  end

  // Asynchronous array read; the top registers the result.
  assign o_rdata = r_mem[i_ridx];
endmodule

module gnrl_ram_1r1w #(
  parameter int DP           = 512,
  parameter int AW           = 32,
  parameter int DW           = 32,
  parameter int MW           = 4,
  parameter bit BYTE_ADDR    = 1'b1,
  parameter bit OUT_REG      = 1'b0,
  parameter bit BYPASS       = 1'b1,
  parameter bit FORCE_X2ZERO = 1'b0
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_wr_en,
  input  logic [AW-1:0] i_wr_addr,
  input  logic [DW-1:0] i_wr_data,
  input  logic [MW-1:0] i_wr_mask,
  input  logic          i_rd_en,
  input  logic [AW-1:0] i_rd_addr,
  output logic [DW-1:0] o_rd_data,
  output logic          o_rd_vld
);
  localparam int SH     = BYTE_ADDR ? $clog2(MW) : 0;
  localparam int IW     = (DP > 1) ? $clog2(DP) : 1;
  localparam int STAGES = OUT_REG ? 2 : 1;

  // Full-width indices: upper address bits take part in the range check,
  // so large addresses never alias onto low entries.
  logic [AW-1:0] w_widx_full, w_ridx_full;
  logic          w_wr_inr, w_rd_inr, w_coll;
  logic [DW-1:0] w_old, w_merged, w_rd_word;

  assign w_widx_full = i_wr_addr >> SH;
  assign w_ridx_full = i_rd_addr >> SH;
  assign w_wr_inr    = (w_widx_full < AW'(DP));
  assign w_rd_inr    = (w_ridx_full < AW'(DP));

  // Same-cycle same-index hit; only matters when bypass is enabled,
  // otherwise the array read naturally returns the pre-write word.
  assign w_coll = BYPASS && i_wr_en && i_rd_en && w_wr_inr && w_rd_inr &&
                  (w_widx_full == w_ridx_full);

  for (genvar g = 0; g < MW; g++) begin : g_lane
    localparam int LO = 8 * g;
    localparam int HI = (g == MW - 1) ? DW - 1 : 8 * g + 7;
    localparam int LW = HI - LO + 1;

    gnrl_ram_1r1w_lane #(.LW(LW), .DP(DP), .IW(IW)) u_lane (
      .i_clk   (i_clk),
      .i_we    (i_wr_en & w_wr_inr & i_wr_mask[g]),
      .i_widx  (w_widx_full[IW-1:0]),
      .i_wdata (i_wr_data[HI:LO]),
      .i_ridx  (w_rd_inr ? w_ridx_full[IW-1:0] : '0),
      .o_rdata (w_old[HI:LO])
    );

    assign w_merged[HI:LO] = (w_coll && i_wr_mask[g]) ? i_wr_data[HI:LO]
                                                       : w_old[HI:LO];
  end

  assign w_rd_word = w_rd_inr ? w_merged : '0;

  // Read pipeline: stage 1 captures the array word, optional stage 2 is the
  // output register. Each stage loads only when a valid read reaches it, so
  // the last stage holds its data between reads.
  logic [STAGES:1]         r_vld_pipe;
  logic [STAGES:1][DW-1:0] r_dat_pipe;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_vld_pipe <= '0;
      r_dat_pipe <= '0;
    end else begin
      r_vld_pipe[1] <= i_rd_en;
      if (i_rd_en) r_dat_pipe[1] <= w_rd_word;
      for (int s = 2; s <= STAGES; s++) begin
        r_vld_pipe[s] <= r_vld_pipe[s-1];
        if (r_vld_pipe[s-1]) r_dat_pipe[s] <= r_dat_pipe[s-1];
      end
    end
  end

  // Optional X scrub on the final output only; any bit that is not a
  // definite 1 becomes 0.
  logic [DW-1:0] w_out;
  always_comb begin
    w_out = r_dat_pipe[STAGES];
    if (FORCE_X2ZERO) begin
      for (int b = 0; b < DW; b++) w_out[b] = (r_dat_pipe[STAGES][b] === 1'b1);
    end
  end

  assign o_rd_data = w_out;
  assign o_rd_vld  = r_vld_pipe[STAGES];
endmodule

// File: tb/tb_gnrl_ram_1r1w.sv
// Directed bench: two instances share the stimulus.
//   A: DP=512, OUT_REG=0, BYPASS=1 (latency 1)
//   B: DP=16,  OUT_REG=1, BYPASS=0 (latency 2)
module tb_gnrl_ram_1r1w;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        wr_en = 1'b0, rd_en = 1'b0;
  logic [31:0] wr_addr = '0, wr_data = '0, rd_addr = '0;
  logic [3:0]  wr_mask = '0;
  logic [31:0] a_data, b_data;
  logic        a_vld, b_vld;
  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  gnrl_ram_1r1w #(.DP(512), .OUT_REG(1'b0), .BYPASS(1'b1)) u_a (
    .i_clk(clk), .i_rst_n(rst_n), .i_wr_en(wr_en), .i_wr_addr(wr_addr),
    .i_wr_data(wr_data), .i_wr_mask(wr_mask), .i_rd_en(rd_en),
    .i_rd_addr(rd_addr), .o_rd_data(a_data), .o_rd_vld(a_vld));

  gnrl_ram_1r1w #(.DP(16), .OUT_REG(1'b1), .BYPASS(1'b0)) u_b (
    .i_clk(clk), .i_rst_n(rst_n), .i_wr_en(wr_en), .i_wr_addr(wr_addr),
    .i_wr_data(wr_data), .i_wr_mask(wr_mask), .i_rd_en(rd_en),
    .i_rd_addr(rd_addr), .o_rd_data(b_data), .o_rd_vld(b_vld));

  // Advance one edge; outputs are then sampled 1ns after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [31:0] addr, input logic [31:0] data,
                    input logic [3:0] mask);
    wr_en = 1'b1; wr_addr = addr; wr_data = data; wr_mask = mask;
    tick();
    wr_en = 1'b0; wr_mask = '0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      total++;
      if (a_vld !== 1'b0 || a_data !== 32'h0) begin
        bad++; $display("FAIL reset_a cyc%0d: vld=%b data=%h want 0/0", i, a_vld, a_data);
      end
      total++;
      if (b_vld !== 1'b0 || b_data !== 32'h0) begin
        bad++; $display("FAIL reset_b cyc%0d: vld=%b data=%h want 0/0", i, b_vld, b_data);
      end
    end
    rst_n = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      total++;
      if (a_vld !== 1'b0 || a_data !== 32'h0 || b_vld !== 1'b0 || b_data !== 32'h0) begin
        bad++; $display("FAIL post_reset cyc%0d: a=%b/%h b=%b/%h want 0/0", i, a_vld, a_data, b_vld, b_data);
      end
    end
  endtask

  task automatic test_byte_mask();
    wr(32'h10, 32'h11223344, 4'hF);
    wr(32'h10, 32'hAABBCCDD, 4'b0101);
    rd_en = 1'b1; rd_addr = 32'h10;
    tick();
    rd_en = 1'b0;
    total++;
    if (a_vld !== 1'b1 || a_data !== 32'h11BB33DD) begin
      bad++; $display("FAIL mask_a_lat1: vld=%b data=%h want 1/11bb33dd", a_vld, a_data);
    end
    total++;
    if (b_vld !== 1'b0) begin
      bad++; $display("FAIL mask_b_early: vld=%b want 0", b_vld);
    end
    tick();
    total++;
    if (b_vld !== 1'b1 || b_data !== 32'h11BB33DD) begin
      bad++; $display("FAIL mask_b_lat2: vld=%b data=%h want 1/11bb33dd", b_vld, b_data);
    end
    total++;
    if (a_vld !== 1'b0 || a_data !== 32'h11BB33DD) begin
      bad++; $display("FAIL mask_a_hold: vld=%b data=%h want 0/11bb33dd", a_vld, a_data);
    end
  endtask

  task automatic test_collision();
    wr(32'h14, 32'h0, 4'hF);
    // full-word collision
    wr_en = 1'b1; wr_addr = 32'h14; wr_data = 32'hCAFEF00D; wr_mask = 4'hF;
    rd_en = 1'b1; rd_addr = 32'h14;
    tick();
    wr_en = 1'b0; rd_en = 1'b0;
    total++;
    if (a_vld !== 1'b1 || a_data !== 32'hCAFEF00D) begin
      bad++; $display("FAIL coll_bypass: vld=%b data=%h want 1/cafef00d", a_vld, a_data);
    end
    tick();
    total++;
    if (b_vld !== 1'b1 || b_data !== 32'h0) begin
      bad++; $display("FAIL coll_nobypass: vld=%b data=%h want 1/00000000", b_vld, b_data);
    end
    // partial-mask collision, then an immediate re-read
    wr_en = 1'b1; wr_data = 32'h12345678; wr_mask = 4'b0011;
    rd_en = 1'b1;
    tick();
    wr_en = 1'b0; wr_mask = '0;
    total++;
    if (a_vld !== 1'b1 || a_data !== 32'hCAFE5678) begin
      bad++; $display("FAIL coll_merge: vld=%b data=%h want 1/cafe5678", a_vld, a_data);
    end
    tick();
    rd_en = 1'b0;
    total++;
    if (a_vld !== 1'b1 || a_data !== 32'hCAFE5678) begin
      bad++; $display("FAIL wr_then_rd_a: vld=%b data=%h want 1/cafe5678", a_vld, a_data);
    end
    total++;
    if (b_vld !== 1'b1 || b_data !== 32'hCAFEF00D) begin
      bad++; $display("FAIL coll_merge_old: vld=%b data=%h want 1/cafef00d", b_vld, b_data);
    end
    tick();
    total++;
    if (b_vld !== 1'b1 || b_data !== 32'hCAFE5678) begin
      bad++; $display("FAIL wr_then_rd_b: vld=%b data=%h want 1/cafe5678", b_vld, b_data);
    end
  endtask

  task automatic test_stream();
    int b_cnt;
    b_cnt = 0;
    for (int i = 0; i < 8; i++) wr(32'(i * 4), 32'(i), 4'hF);
    for (int k = 0; k < 11; k++) begin
      rd_en = (k < 8); rd_addr = 32'(k * 4);
      tick();
      if (b_vld === 1'b1) b_cnt++;
      total++;
      if (a_vld !== (k < 8) || a_data !== 32'((k < 8) ? k : 7)) begin
        bad++; $display("FAIL stream_a k=%0d: vld=%b data=%h want %b/%h", k, a_vld, a_data, (k < 8), (k < 8) ? k : 7);
      end
      total++;
      if (b_vld !== (k >= 1 && k <= 8)) begin
        bad++; $display("FAIL stream_b_vld k=%0d: vld=%b want %b", k, b_vld, (k >= 1 && k <= 8));
      end
      if (k >= 1) begin
        total++;
        if (b_data !== 32'((k <= 8) ? k - 1 : 7)) begin
          bad++; $display("FAIL stream_b_data k=%0d: data=%h want %h", k, b_data, (k <= 8) ? k - 1 : 7);
        end
      end
    end
    rd_en = 1'b0;
    total++;
    if (b_cnt != 8) begin
      bad++; $display("FAIL stream_b_count: got %0d want 8", b_cnt);
    end
  endtask

  task automatic test_out_of_range();
    wr(32'h0, 32'hA5A5A5A5, 4'hF);
    wr(32'h40, 32'hFFFFFFFF, 4'hF);        // idx 16: dropped by B
    wr(32'h8000_0000, 32'h5A5A5A5A, 4'hF); // huge idx: dropped by both
    rd_en = 1'b1; rd_addr = 32'h40;
    tick();
    total++;
    if (a_vld !== 1'b1 || a_data !== 32'hFFFFFFFF) begin
      bad++; $display("FAIL oor_a_inrange: vld=%b data=%h want 1/ffffffff", a_vld, a_data);
    end
    rd_addr = 32'h0;
    tick();
    total++;
    if (a_vld !== 1'b1 || a_data !== 32'hA5A5A5A5) begin
      bad++; $display("FAIL oor_a_idx0: vld=%b data=%h want 1/a5a5a5a5", a_vld, a_data);
    end
    total++;
    if (b_vld !== 1'b1 || b_data !== 32'h0) begin
      bad++; $display("FAIL oor_b_read: vld=%b data=%h want 1/00000000", b_vld, b_data);
    end
    rd_addr = 32'h8000_0000;
    tick();
    rd_en = 1'b0;
    total++;
    if (a_vld !== 1'b1 || a_data !== 32'h0) begin
      bad++; $display("FAIL oor_a_high: vld=%b data=%h want 1/00000000", a_vld, a_data);
    end
    total++;
    if (b_vld !== 1'b1 || b_data !== 32'hA5A5A5A5) begin
      bad++; $display("FAIL oor_b_idx0: vld=%b data=%h want 1/a5a5a5a5", b_vld, b_data);
    end
    tick();
    total++;
    if (b_vld !== 1'b1 || b_data !== 32'h0) begin
      bad++; $display("FAIL oor_b_high: vld=%b data=%h want 1/00000000", b_vld, b_data);
    end
  endtask

  task automatic test_reset_mid_read();
    rd_en = 1'b1; rd_addr = 32'h0;
    tick();
    rd_en = 1'b0;
    total++;
    if (a_vld !== 1'b1 || a_data !== 32'hA5A5A5A5) begin
      bad++; $display("FAIL midrst_a_pre: vld=%b data=%h want 1/a5a5a5a5", a_vld, a_data);
    end
    rst_n = 1'b0;
    #1;
    total++;
    if (a_vld !== 1'b0 || a_data !== 32'h0 || b_vld !== 1'b0 || b_data !== 32'h0) begin
      bad++; $display("FAIL midrst_clear: a=%b/%h b=%b/%h want 0/0", a_vld, a_data, b_vld, b_data);
    end
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      total++;
      if (b_vld !== 1'b0) begin
        bad++; $display("FAIL midrst_no_vld cyc%0d: vld=%b want 0", i, b_vld);
      end
    end
    rd_en = 1'b1; rd_addr = 32'h0;
    tick();
    rd_en = 1'b0;
    tick();
    total++;
    if (b_vld !== 1'b1 || b_data !== 32'hA5A5A5A5) begin
      bad++; $display("FAIL midrst_reread: vld=%b data=%h want 1/a5a5a5a5", b_vld, b_data);
    end
  endtask

  initial begin
    test_reset();
    test_byte_mask();
    test_collision();
    test_stream();
    test_out_of_range();
    test_reset_mid_read();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
